// File: rtl/idli_sqi_rsp_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_sqi_rsp_m
// Purpose  : Single-device SQI SRAM responder. Decodes READ (0x03) and
//            WRITE (0x02) quad-SPI transactions from the core's SQI
//            initiator and maps them onto a byte-wide synchronous storage
//            port. One instance per chip select.
// Ports    : i_srsp_gck          core clock (only clock)
//            i_srsp_rst_n        asynchronous active-low reset
//            i_srsp_sck          transfer qualifier (slice moves when 1)
//            i_srsp_cs           chip select, active low
//            i_srsp_sio          4-bit slice from the initiator
//            o_srsp_sio          4-bit slice to the initiator
//            o_srsp_sio_en       responder drives sio
//            o_srsp_mem_addr     storage byte address
//            o_srsp_mem_rd_en    read strobe (data returns 1 cycle later)
//            o_srsp_mem_wr_en    write strobe (single-cycle pulse)
//            o_srsp_mem_wr_data  write byte
//            i_srsp_mem_rd_data  read byte, valid the cycle after rd_en
// Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_rsp_m #(
  parameter int ADDR_W       = 16,
  parameter int DUMMY_SLICES = 2   // must be 2 or more
) (
  input  logic              i_srsp_gck,
  input  logic              i_srsp_rst_n,
  input  logic              i_srsp_sck,
  input  logic              i_srsp_cs,
  input  logic [3:0]        i_srsp_sio,
  output logic [3:0]        o_srsp_sio,
  output logic              o_srsp_sio_en,
  output logic [ADDR_W-1:0] o_srsp_mem_addr,
  output logic              o_srsp_mem_rd_en,
  output logic              o_srsp_mem_wr_en,
  output logic [7:0]        o_srsp_mem_wr_data,
  input  logic [7:0]        i_srsp_mem_rd_data
);

  localparam int ADDR_SLICES = ADDR_W / 4;
  localparam int MAX_CNT     = (ADDR_SLICES > DUMMY_SLICES) ? ADDR_SLICES : DUMMY_SLICES;
  localparam int CNT_W       = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LAST  = CNT_W'(ADDR_SLICES - 1);
  localparam logic [CNT_W-1:0] C_DUMMY_LAST = CNT_W'(DUMMY_SLICES - 1);
  localparam logic [7:0]       C_INSTR_WR   = 8'h02;
  localparam logic [7:0]       C_INSTR_RD   = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INSTR  = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_WDATA  = 3'd4,
    S_RDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [3:0]          instr_q,    instr_d;     // first instruction nibble
  logic                is_rd_q,    is_rd_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;      // address of current byte
  logic                nib_q,      nib_d;       // 0: next XE is a high nibble
  logic [3:0]          hold_q,     hold_d;      // write high nibble / read low nibble
  logic [7:0]          buf_q,      buf_d;       // prefetched read byte
  logic                rd_pend_q,  rd_pend_d;   // read data arrives this cycle
  logic [3:0]          sio_q,      sio_d;
  logic                sio_en_q,   sio_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                rd_en_q,    rd_en_d;
  logic                wr_en_q,    wr_en_d;
  logic [7:0]          wr_data_q,  wr_data_d;

  logic                w_xe;
  logic [7:0]          w_rd_src;
  logic [ADDR_W-1:0]   w_addr_shift;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign w_xe         = ~i_srsp_cs & i_srsp_sck;
  // Forward the memory output directly when it lands on the same edge the
  // high nibble must be launched; otherwise the buffered copy is current.
  assign w_rd_src     = rd_pend_q ? i_srsp_mem_rd_data : buf_q;
  assign w_addr_shift = {addr_q[ADDR_W-5:0], i_srsp_sio};
  assign w_addr_inc   = addr_q + ADDR_W'(1);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    nib_d      = nib_q;
    hold_d     = hold_q;
    sio_d      = sio_q;
    sio_en_d   = sio_en_q;
    mem_addr_d = mem_addr_q;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    // Storage returns data one cycle after the strobe; capture it then.
    rd_pend_d  = rd_en_q;
    buf_d      = rd_pend_q ? i_srsp_mem_rd_data : buf_q;

    if (i_srsp_cs) begin
      // Deselect wins over any simultaneous transfer.
      state_d  = S_IDLE;
      cnt_d    = '0;
      nib_d    = 1'b0;
      sio_en_d = 1'b0;
      sio_d    = 4'h0;
    end else if (w_xe) begin
      case (state_q)
        S_IDLE: begin
          instr_d = i_srsp_sio;
          state_d = S_INSTR;
        end

        S_INSTR: begin
          cnt_d = '0;
          if ({instr_q, i_srsp_sio} == C_INSTR_WR) begin
            is_rd_d = 1'b0;
            state_d = S_ADDR;
          end else if ({instr_q, i_srsp_sio} == C_INSTR_RD) begin
            is_rd_d = 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_IGNORE;
          end
        end

        S_ADDR: begin
          addr_d = w_addr_shift;
          if (cnt_q == C_ADDR_LAST) begin
            cnt_d = '0;
            nib_d = 1'b0;
            if (is_rd_q) begin
              // Fetch the start byte now so it is ready by the last dummy.
              mem_addr_d = w_addr_shift;
              rd_en_d    = 1'b1;
              state_d    = S_DUMMY;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DUMMY: begin
          if (cnt_q == C_DUMMY_LAST) begin
            cnt_d      = '0;
            state_d    = S_RDATA;
            sio_en_d   = 1'b1;
            sio_d      = w_rd_src[7:4];
            hold_d     = w_rd_src[3:0];
            nib_d      = 1'b1;
            mem_addr_d = w_addr_inc;
            addr_d     = w_addr_inc;
            rd_en_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RDATA: begin
          if (nib_q) begin
            sio_d = hold_q;
            nib_d = 1'b0;
          end else begin
            // Launch next high nibble and prefetch the byte after it.
            sio_d      = w_rd_src[7:4];
            hold_d     = w_rd_src[3:0];
            nib_d      = 1'b1;
            mem_addr_d = w_addr_inc;
            addr_d     = w_addr_inc;
            rd_en_d    = 1'b1;
          end
        end

        S_WDATA: begin
          if (!nib_q) begin
            hold_d = i_srsp_sio;
            nib_d  = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_data_d  = {hold_q, i_srsp_sio};
            mem_addr_d = addr_q;
            addr_d     = w_addr_inc;
            nib_d      = 1'b0;
          end
        end

        S_IGNORE: begin
          state_d = S_IGNORE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_srsp_gck or negedge i_srsp_rst_n) begin
    if (!i_srsp_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      instr_q    <= 4'h0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      nib_q      <= 1'b0;
      hold_q     <= 4'h0;
      buf_q      <= 8'h00;
      rd_pend_q  <= 1'b0;
      sio_q      <= 4'h0;
      sio_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      nib_q      <= nib_d;
      hold_q     <= hold_d;
      buf_q      <= buf_d;
      rd_pend_q  <= rd_pend_d;
      sio_q      <= sio_d;
      sio_en_q   <= sio_en_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_srsp_sio         = sio_q;
  assign o_srsp_sio_en      = sio_en_q;
  assign o_srsp_mem_addr    = mem_addr_q;
  assign o_srsp_mem_rd_en   = rd_en_q;
  assign o_srsp_mem_wr_en   = wr_en_q;
  assign o_srsp_mem_wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_rsp_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_rsp_m
// Purpose  : Self-checking bench for idli_sqi_rsp_m with a byte-wide
//            synchronous storage model behind the responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_rsp_m;

  localparam int DUMMY = 2;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        cs;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic        sio_en;
  logic [15:0] maddr;
  logic        rd_en;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;

  logic [7:0]  mem [0:65535];
  logic [23:0] wlog [$];

  int checks = 0;
  int errors = 0;

  idli_sqi_rsp_m #(.ADDR_W(16), .DUMMY_SLICES(DUMMY)) dut (
    .i_srsp_gck         (clk),
    .i_srsp_rst_n       (rst_n),
    .i_srsp_sck         (sck),
    .i_srsp_cs          (cs),
    .i_srsp_sio         (sio_in),
    .o_srsp_sio         (sio_out),
    .o_srsp_sio_en      (sio_en),
    .o_srsp_mem_addr    (maddr),
    .o_srsp_mem_rd_en   (rd_en),
    .o_srsp_mem_wr_en   (wr_en),
    .o_srsp_mem_wr_data (wr_data),
    .i_srsp_mem_rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous storage: read data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[maddr] <= wr_data;
      wlog.push_back({maddr, wr_data});
    end
    if (rd_en) rd_data <= mem[maddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic slice(input logic [3:0] n);
    @(negedge clk);
    cs = 1'b0; sck = 1'b1; sio_in = n;
    @(posedge clk); #1;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      sck = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic end_cs();
    @(negedge clk);
    cs = 1'b1; sck = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic send_addr(input logic [15:0] a);
    for (int i = 3; i >= 0; i--) slice(a[i*4 +: 4]);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input int gap);
    int n0;
    logic [15:0] a1;
    n0 = wlog.size();
    a1 = a + 16'd1;
    slice(4'h0); slice(4'h2);
    send_addr(a);
    slice(d0[7:4]);
    stall(gap);
    chk("wr_en_before_lo", {31'b0, wr_en}, 0);
    slice(d0[3:0]);
    chk("wr_en_pulse0", {31'b0, wr_en}, 1);
    chk("wr_addr0", {16'b0, maddr}, {16'b0, a});
    chk("wr_data0", {24'b0, wr_data}, {24'b0, d0});
    slice(d1[7:4]);
    chk("wr_en_one_cycle", {31'b0, wr_en}, 0);
    slice(d1[3:0]);
    chk("wr_addr1", {16'b0, maddr}, {16'b0, a1});
    chk("wr_data1", {24'b0, wr_data}, {24'b0, d1});
    end_cs();
    chk("wr_count", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) chk("wr_log1", {8'b0, wlog[n0+1]}, {8'b0, a1, d1});
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] e0, input logic [7:0] e1, input int gap);
    logic [15:0] got;
    slice(4'h0); slice(4'h3);
    send_addr(a);
    chk("rd_issue", {31'b0, rd_en}, 1);
    chk("rd_addr", {16'b0, maddr}, {16'b0, a});
    for (int i = 0; i < DUMMY - 1; i++) begin
      slice(4'h0);
      chk("sio_en_dummy", {31'b0, sio_en}, 0);
    end
    slice(4'h0);
    chk("sio_en_rise", {31'b0, sio_en}, 1);
    got[15:12] = sio_out;
    for (int k = 1; k < 4; k++) begin
      stall(gap);
      slice(4'h0);
      got[15-4*k -: 4] = sio_out;
    end
    stall(gap);
    slice(4'h0);
    chk("sio_en_hold", {31'b0, sio_en}, 1);
    chk("rd_bytes", {16'b0, got}, {16'b0, e0, e1});
    end_cs();
    chk("sio_en_fall", {31'b0, sio_en}, 0);
  endtask

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  b0;    // write data, or expected read byte
    logic [7:0]  b1;
    int          gap;   // sck-low cycles inserted between nibbles
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n0;
    bit bad;

    vecs[0] = '{1'b0, 16'h1234, 8'hAB, 8'hCD, 0};
    vecs[1] = '{1'b1, 16'h1234, 8'hAB, 8'hCD, 0};
    vecs[2] = '{1'b0, 16'hFFFF, 8'h5A, 8'h3C, 0};
    vecs[3] = '{1'b1, 16'hFFFF, 8'h5A, 8'h3C, 0};
    vecs[4] = '{1'b0, 16'h0400, 8'h77, 8'hE1, 3};
    vecs[5] = '{1'b1, 16'h0400, 8'h77, 8'hE1, 1};
    vecs[6] = '{1'b0, 16'h00F0, 8'h12, 8'h34, 0};
    vecs[7] = '{1'b1, 16'h00F0, 8'h12, 8'h34, 2};

    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sio", {28'b0, sio_out}, 0);
    chk("rst_sio_en", {31'b0, sio_en}, 0);
    chk("rst_addr", {16'b0, maddr}, 0);
    chk("rst_rd_en", {31'b0, rd_en}, 0);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_wr_data", {24'b0, wr_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rd) do_read(vecs[v].addr, vecs[v].b0, vecs[v].b1, vecs[v].gap);
      else            do_write(vecs[v].addr, vecs[v].b0, vecs[v].b1, vecs[v].gap);
    end

    // Unknown instruction: bus stays quiet until deselected.
    n0 = wlog.size();
    bad = 1'b0;
    slice(4'h0); slice(4'h5);
    for (int i = 0; i < 10; i++) begin
      slice(i[3:0]);
      if (rd_en || wr_en || sio_en) bad = 1'b1;
    end
    end_cs();
    chk("ign_quiet", {31'b0, bad}, 0);
    chk("ign_no_write", wlog.size() - n0, 0);
    do_read(16'h1234, 8'hAB, 8'hCD, 0);

    // Deselect after a single data nibble: the partial byte is dropped.
    n0 = wlog.size();
    slice(4'h0); slice(4'h2);
    send_addr(16'h0500);
    slice(4'h9);
    end_cs();
    chk("partial_no_write", wlog.size() - n0, 0);
    do_write(16'h0500, 8'h66, 8'h99, 0);
    do_read(16'h0500, 8'h66, 8'h99, 0);

    // Reset in the middle of the data phase.
    slice(4'h0); slice(4'h3);
    send_addr(16'h1234);
    for (int i = 0; i < DUMMY; i++) slice(4'h0);
    slice(4'h0);
    chk("pre_rst_sio_en", {31'b0, sio_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {4'b0, sio_out, sio_en, maddr, rd_en, wr_en, wr_data},
        32'h0);
    cs = 1'b1; sck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(16'hFFFF, 8'h5A, 8'h3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/idli_sqi_rsp_m.md
# idli_sqi_rsp_m

Single-device SQI SRAM responder: the memory end of the core's quad-SPI memory bus. Decodes READ/WRITE transactions issued by the core's SQI initiator and maps them onto a simple byte-wide synchronous storage port. Used as the bench and FPGA memory model behind either the low or high memory interface; one instance per chip select.

## Interface

Parameters:
- `ADDR_W`, 16, byte-address width; address wraps modulo 2^ADDR_W.
- `DUMMY_SLICES`, 2, dummy slices between address and read data; legal range is 2 or more.

Ports:
- `i_srsp_gck`  in  1  core clock; the only clock.
- `i_srsp_rst_n`  in  1  asynchronous, active-low reset.
- `i_srsp_sck`  in  1  transfer qualifier; a slice transfers on each gck rising edge with sck=1 and cs=0.
- `i_srsp_cs`  in  1  chip select, active low.
- `i_srsp_sio`  in  slice_t  slice from initiator.
- `o_srsp_sio`  out  slice_t  slice to initiator.
- `o_srsp_sio_en`  out  1  responder drives sio.
- `o_srsp_mem_addr`  out  ADDR_W  storage byte address.
- `o_srsp_mem_rd_en`  out  1  read strobe; data returns exactly 1 cycle later.
- `o_srsp_mem_wr_en`  out  1  write strobe.
- `o_srsp_mem_wr_data`  out  8  write byte.
- `i_srsp_mem_rd_data`  in  8  read byte, valid the cycle after rd_en.

## Operation

- Transfer edge (XE): gck rising edge with cs=0 and sck=1. Cycles with sck=0 stall all state.
- Nibble order is MSB first: instruction, address (high nibble first), and data (high nibble then low nibble of each byte).
- States:
  - IDLE: waits for cs=0.
  - INSTR: 2 slices.
  - ADDR: ADDR_W/4 slices.
  - DUMMY: reads only, DUMMY_SLICES slices.
  - WDATA / RDATA: data phase.
  - IGNORE: waits for cs=1.
- Instruction decode after the 2nd slice:
  - 0x02 selects WRITE: ADDR, then WDATA.
  - 0x03 selects READ: ADDR, DUMMY, then RDATA.
  - Any other value goes to IGNORE; no storage access and sio_en stays 0.
- WDATA:
  - The 2nd nibble of each byte pulses mem_wr_en for 1 cycle, with the assembled byte and the current address.
  - The address then increments.
- RDATA:
  - A read of the start address issues the cycle after the final address XE.
  - The returned byte is captured in a byte buffer.
  - The first high nibble appears on o_srsp_sio after the last dummy XE.
  - Each XE advances to the next nibble.
  - After each high-nibble XE, a prefetch read of address+1 issues; the address then increments.
- Address arithmetic is ADDR_W-bit unsigned; 2^ADDR_W-1 increments to 0.
- cs=1 in any state returns to IDLE on the next edge, clears counters, drops sio_en, and discards any partial write byte.
- cs deasserting on the same edge as an XE: cs wins and no transfer occurs.

## Timing

- Reset values: o_srsp_sio=0, o_srsp_sio_en=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0; state IDLE.
- Reset asserted mid-transaction aborts it immediately. Storage strobes are low from the reset assertion.
- All outputs are registered; there is no combinational path from inputs to outputs.
- o_srsp_sio_en rises on the last dummy XE and falls on the first edge with cs=1.
- Read path: a slice driven after XE n is sampled by the initiator at XE n+1.
- With back-to-back XEs, prefetch latency (issue 1 cycle after the high-nibble XE, data 1 cycle later) lands exactly at the low-nibble XE. The low nibble comes from the buffer, and the buffer reloads after the low-nibble XE.
- Write strobe: asserted in the cycle after the low-nibble XE, high for exactly 1 cycle.

## Test plan

- WRITE 0x02, addr 0x1234, data slices A,B,C,D, then cs high -> wr_en pulses with 0x1234=0xAB and 0x1235=0xCD; exactly 2 writes.
- Storage preloaded 0x1234=0xAB, 0x1235=0xCD; READ 0x03 addr 0x1234, 2 dummy slices, 4 data XEs -> sampled slices A,B,C,D; sio_en high from the last dummy XE until cs high.
- READ at 0xFFFF for 2 bytes with back-to-back XEs -> bytes from 0xFFFF then 0x0000.
- Instruction 0x05 followed by 10 slices -> no rd/wr strobes and sio_en=0 throughout; the next transaction after cs high decodes normally.
- WRITE with sck held low for 3 cycles between the two data nibbles -> a single write, identical to the gap-free case. cs high after 1 data nibble -> no write.
- rst_n asserted during RDATA -> all outputs 0 immediately; after release, a fresh READ returns correct data.
